// File: rtl/harness_pkg.sv
// Shared types and MISR step function for the stimulus/compaction harness.
// misr_next works on a wide container; callers zero-extend and truncate to their width.
package harness_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MISR_MAX_W = 256;
    localparam logic [MISR_MAX_W-1:0] DEF_POLY = MISR_MAX_W'('h1D);
    localparam logic [MISR_MAX_W-1:0] DEF_SEED = '0;

    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic [MISR_MAX_W-1:0] din,
        input logic [MISR_MAX_W-1:0] poly,
        input int                    w
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = (MISR_MAX_W'(1) << w) - MISR_MAX_W'(1);
        nxt  = (sig << 1) ^ (sig[w-1] ? poly : '0) ^ din;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/misr_compactor.sv
// Multiple-input signature register: folds one response word per enabled cycle.
// clr has priority over en so a new run always starts from SEED.
module misr_compactor
    import harness_pkg::*;
#(
    parameter int               OUT_W = 82,
    parameter logic [OUT_W-1:0] POLY  = OUT_W'(DEF_POLY),
    parameter logic [OUT_W-1:0] SEED  = OUT_W'(DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [OUT_W-1:0] din,
    output logic [OUT_W-1:0] sig
);

    logic [OUT_W-1:0] sig_q;
    logic [OUT_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = SEED;
        end else if (en) begin
            sig_d = OUT_W'(misr_next(MISR_MAX_W'(sig_q), MISR_MAX_W'(din),
                                     MISR_MAX_W'(POLY), OUT_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;

endmodule

// File: rtl/stim_misr_harness.sv
// Replays stored vectors (with optional zero gaps) into a DUT and compacts its
// response into a MISR signature checked against a golden value.
module stim_misr_harness
    import harness_pkg::*;
#(
    parameter int               IN_W    = 53,
    parameter int               OUT_W   = 82,
    parameter int               DEPTH   = 32,
    parameter int               HOLD    = 1,
    parameter int               GAP_LEN = 1,
    parameter logic [OUT_W-1:0] POLY    = OUT_W'(DEF_POLY),
    parameter logic [OUT_W-1:0] SEED    = OUT_W'(DEF_SEED),
    localparam int              AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [IN_W-1:0]  cfg_vec,
    input  logic             cfg_gap,
    input  logic [AW:0]      num_vec,
    input  logic             start,
    input  logic [OUT_W-1:0] expected_sig,
    output logic [IN_W-1:0]  dut_in,
    input  logic [OUT_W-1:0] dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature,
    output logic [AW-1:0]    vec_idx
);

    localparam int             HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int             GW        = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam logic [AW:0]    DEPTH_N   = (AW+1)'(DEPTH);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(HOLD - 1);
    localparam logic [GW-1:0]  GAP_LAST  = GW'(GAP_LEN - 1);

    // Each entry is {gap_flag, vector}; not reset.
    logic [IN_W:0]   mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [IN_W-1:0] dut_in_q, dut_in_d;
    logic            gap_q, gap_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [AW:0]     num_q, num_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [GW-1:0]   gcnt_q, gcnt_d;
    logic            pass_q, pass_d;
    logic            misr_clr, misr_en;
    logic [AW-1:0]   rd_addr;
    logic [IN_W:0]   rd_word;
    logic            more;
    logic            busy_w;

    assign busy_w  = (state_q == APPLY) || (state_q == GAP);
    assign rd_word = mem_q[rd_addr];
    assign more    = ({1'b0, idx_q} + (AW+1)'(1)) < num_q;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy_w) begin
            mem_q[cfg_addr] <= {cfg_gap, cfg_vec};
        end
    end

    always_comb begin
        state_d  = state_q;
        dut_in_d = dut_in_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        num_d    = num_q;
        hold_d   = hold_q;
        gcnt_d   = gcnt_q;
        pass_d   = pass_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        rd_addr  = idx_q + AW'(1);
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d    = (num_vec > DEPTH_N) ? DEPTH_N : num_vec;
                    misr_clr = 1'b1;
                    pass_d   = 1'b0;
                    idx_d    = '0;
                    hold_d   = '0;
                    if (num_vec == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d           = APPLY;
                        rd_addr           = '0;
                        {gap_d, dut_in_d} = rd_word;
                    end
                end
            end
            APPLY: begin
                if (hold_q == HOLD_LAST) begin
                    misr_en = 1'b1;
                    hold_d  = '0;
                    if (gap_q) begin
                        state_d  = GAP;
                        dut_in_d = '0;
                        gcnt_d   = '0;
                    end else if (more) begin
                        idx_d             = rd_addr;
                        {gap_d, dut_in_d} = rd_word;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    if (more) begin
                        state_d           = APPLY;
                        idx_d             = rd_addr;
                        {gap_d, dut_in_d} = rd_word;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            DONE: begin
                pass_d   = (signature == expected_sig);
                dut_in_d = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            dut_in_q <= '0;
            gap_q    <= 1'b0;
            idx_q    <= '0;
            num_q    <= '0;
            hold_q   <= '0;
            gcnt_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dut_in_q <= dut_in_d;
            gap_q    <= gap_d;
            idx_q    <= idx_d;
            num_q    <= num_d;
            hold_q   <= hold_d;
            gcnt_q   <= gcnt_d;
            pass_q   <= pass_d;
        end
    end

    misr_compactor #(
        .OUT_W (OUT_W),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr),
        .en    (misr_en),
        .din   (dut_out),
        .sig   (signature)
    );

    assign dut_in  = dut_in_q;
    assign busy    = busy_w;
    assign done    = (state_q == DONE);
    assign pass    = pass_q;
    assign vec_idx = idx_q;

endmodule

// File: tb/tb_stim_misr_harness.sv
// Directed bench: 8-bit loopback (dut_out = dut_in), DEPTH=4, HOLD=1, GAP_LEN=2.
module tb_stim_misr_harness;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_vec = '0;
    logic       cfg_gap = 1'b0;
    logic [2:0] num_vec = '0;
    logic       start = 1'b0;
    logic [7:0] expected_sig = '0;
    logic [7:0] dut_in;
    logic       busy, done, pass;
    logic [7:0] signature;
    logic [1:0] vec_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] din_log [40];
    logic [7:0] sig_log [40];
    logic [1:0] idx_log [40];
    int busy_cycles, done_cycles, done_at, last_busy;

    always #5 clk = ~clk;

    stim_misr_harness #(
        .IN_W(8), .OUT_W(8), .DEPTH(4), .HOLD(1), .GAP_LEN(2),
        .POLY(8'h1D), .SEED(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_vec(cfg_vec), .cfg_gap(cfg_gap), .num_vec(num_vec), .start(start),
        .expected_sig(expected_sig), .dut_in(dut_in), .dut_out(dut_in),
        .busy(busy), .done(done), .pass(pass), .signature(signature),
        .vec_idx(vec_idx)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_vec(input logic [1:0] a, input logic [7:0] v, input logic g);
        cfg_we = 1'b1; cfg_addr = a; cfg_vec = v; cfg_gap = g;
        step();
        cfg_we = 1'b0;
    endtask

    // Starts a run and logs outputs every cycle until two cycles past done (or a cycle budget).
    task automatic run(input logic [2:0] n, input logic [7:0] exp_sig,
                       input int inject_cyc, input bit coll_write);
        num_vec = n; expected_sig = exp_sig;
        if (coll_write) begin
            cfg_we = 1'b1; cfg_addr = 2'd0; cfg_vec = 8'h55; cfg_gap = 1'b0;
        end
        start = 1'b1;
        step();
        start = 1'b0; cfg_we = 1'b0;
        busy_cycles = 0; done_cycles = 0; done_at = -1; last_busy = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            din_log[cyc] = dut_in; sig_log[cyc] = signature; idx_log[cyc] = vec_idx;
            if (busy) begin busy_cycles++; last_busy = cyc; end
            if (done) begin done_cycles++; if (done_at < 0) done_at = cyc; end
            if (done_at >= 0 && cyc == done_at + 2) break;
            start = (cyc == inject_cyc);
            step();
            start = 1'b0;
        end
        $display("run n=%0d exp=%02h: busy=%0d done_at=%0d sig=%02h pass=%0b",
                 n, exp_sig, busy_cycles, done_at, signature, pass);
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (dut_in !== 8'h00) begin n_fail++; $display("FAIL reset_dut_in got %02h want 00", dut_in); end
        n_checks++; if ({busy, done, pass} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %03b want 000", {busy, done, pass}); end
        n_checks++; if (signature !== 8'h00) begin n_fail++; $display("FAIL reset_sig got %02h want 00", signature); end
        n_checks++; if (vec_idx !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d want 0", vec_idx); end
        repeat (2) step();
        rst_n = 1'b1;
        step();
        $display("reset checked");
    endtask

    task automatic test_four_vector();
        write_vec(2'd0, 8'h01, 1'b0); write_vec(2'd1, 8'h02, 1'b0);
        write_vec(2'd2, 8'h80, 1'b0); write_vec(2'd3, 8'h01, 1'b0);
        run(3'd4, 8'h1C, -1, 1'b0);
        n_checks++; if ({din_log[0], din_log[1], din_log[2], din_log[3]} !== 32'h01028001) begin n_fail++; $display("FAIL fv_dut_in got %02h %02h %02h %02h want 01 02 80 01", din_log[0], din_log[1], din_log[2], din_log[3]); end
        n_checks++; if ({sig_log[1], sig_log[2], sig_log[3], sig_log[4]} !== 32'h0100801C) begin n_fail++; $display("FAIL fv_sig_steps got %02h %02h %02h %02h want 01 00 80 1C", sig_log[1], sig_log[2], sig_log[3], sig_log[4]); end
        n_checks++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL fv_busy got %0d want 4", busy_cycles); end
        n_checks++; if (done_at !== last_busy + 1 || done_cycles !== 1) begin n_fail++; $display("FAIL fv_done got at=%0d count=%0d want at=%0d count=1", done_at, done_cycles, last_busy + 1); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL fv_pass got %0b want 1", pass); end
    endtask

    task automatic test_zero_count();
        run(3'd0, 8'h00, -1, 1'b0);
        n_checks++; if (done_at !== 0 || busy_cycles !== 0) begin n_fail++; $display("FAIL zc_timing got done_at=%0d busy=%0d want 0 0", done_at, busy_cycles); end
        n_checks++; if (signature !== 8'h00) begin n_fail++; $display("FAIL zc_sig got %02h want 00", signature); end
        n_checks++; if (pass !== 1'b1) begin n_fail++; $display("FAIL zc_pass got %0b want 1", pass); end
    endtask

    task automatic test_gap();
        write_vec(2'd0, 8'h01, 1'b1); write_vec(2'd1, 8'h02, 1'b0);
        run(3'd2, 8'h00, -1, 1'b0);
        n_checks++; if ({din_log[0], din_log[1], din_log[2], din_log[3]} !== 32'h01000002) begin n_fail++; $display("FAIL gap_dut_in got %02h %02h %02h %02h want 01 00 00 02", din_log[0], din_log[1], din_log[2], din_log[3]); end
        n_checks++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL gap_busy got %0d want 4", busy_cycles); end
        n_checks++; if (signature !== 8'h00 || pass !== 1'b1) begin n_fail++; $display("FAIL gap_sig got %02h pass=%0b want 00 pass=1", signature, pass); end
    endtask

    task automatic test_clamp();
        write_vec(2'd0, 8'h01, 1'b0); write_vec(2'd1, 8'h02, 1'b0);
        run(3'd7, 8'hFF, -1, 1'b0);
        n_checks++; if (busy_cycles !== 4) begin n_fail++; $display("FAIL clamp_busy got %0d want 4", busy_cycles); end
        n_checks++; if (done_at < 1 || idx_log[done_at - 1] !== 2'd3) begin n_fail++; $display("FAIL clamp_idx got %0d want 3", (done_at < 1) ? -1 : int'(idx_log[done_at - 1])); end
        n_checks++; if (signature !== 8'h1C || pass !== 1'b0) begin n_fail++; $display("FAIL clamp_pass got sig=%02h pass=%0b want 1C pass=0", signature, pass); end
    endtask

    task automatic test_reset_mid_run();
        num_vec = 3'd4; expected_sig = 8'h1C;
        start = 1'b1; step(); start = 1'b0;
        step();
        n_checks++; if (dut_in !== 8'h02) begin n_fail++; $display("FAIL mid_second_vec got %02h want 02", dut_in); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({dut_in, busy, signature} !== 17'h0) begin n_fail++; $display("FAIL mid_reset got dut_in=%02h busy=%0b sig=%02h want 00 0 00", dut_in, busy, signature); end
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_no_resume got busy=%0b want 0", busy); end
        run(3'd4, 8'h1C, -1, 1'b0);
        n_checks++; if (signature !== 8'h1C || pass !== 1'b1 || din_log[0] !== 8'h01) begin n_fail++; $display("FAIL mid_rerun got sig=%02h pass=%0b first=%02h want 1C 1 01", signature, pass, din_log[0]); end
    endtask

    task automatic test_back_to_back();
        run(3'd4, 8'h1C, 1, 1'b1);
        n_checks++; if (din_log[0] !== 8'h01) begin n_fail++; $display("FAIL coll_first got %02h want 01", din_log[0]); end
        n_checks++; if (busy_cycles !== 4 || done_cycles !== 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_start got busy=%0d done=%0d now=%0b want 4 1 0", busy_cycles, done_cycles, busy); end
        n_checks++; if (signature !== 8'h1C || pass !== 1'b1) begin n_fail++; $display("FAIL coll_sig got %02h pass=%0b want 1C 1", signature, pass); end
        run(3'd4, 8'h86, -1, 1'b0);
        n_checks++; if (din_log[0] !== 8'h55 || signature !== 8'h86 || pass !== 1'b1) begin n_fail++; $display("FAIL coll_commit got first=%02h sig=%02h pass=%0b want 55 86 1", din_log[0], signature, pass); end
    endtask

    initial begin
        test_reset();
        test_four_vector();
        test_zero_count();
        test_gap();
        test_clamp();
        test_reset_mid_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
